// File: rtl/qq_host_port_if.sv
// Host-facing command/response channel of the QuickQueue front end.
// The host drives commands and takes responses; the port is the slave.
interface qq_host_port_if;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_empty;
  logic        rsp_err;
  logic        rsp_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_empty, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_empty, rsp_err
  );
endinterface

// File: rtl/qq_host_port.sv
// QuickQueue host front end: turns host commands into node-chain strobes,
// tracks occupancy locally and returns data/status on the response channel.
module qq_host_port #(
  parameter int CAPACITY   = 255,
  parameter int TIMEOUT    = 64,
  parameter int CLR_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset_i,
  qq_host_port_if.slave host,
  output logic [31:0]   node_data_o,
  output logic          node_write_o,
  output logic          node_read_o,
  output logic          node_reset_o,
  input  logic [31:0]   node_data_i,
  input  logic          node_done_i,
  output logic [7:0]    count_o
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [1:0] OP_ENQ = 2'b00, OP_DEQ = 2'b01, OP_CLR = 2'b10;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, CLEAR} state_t;

  state_t          state, state_nxt;
  logic [1:0]      op_q;
  logic [31:0]     data_q;
  logic [TW-1:0]   tcnt;
  logic [CW-1:0]   ccnt;
  logic [31:0]     rsp_data_q;
  logic            rsp_empty_q, rsp_err_q;
  logic [7:0]      count_q;
  logic            accept, full, empty, tmo_hit, clr_last;

  assign full     = (count_q == 8'(CAPACITY));
  assign empty    = (count_q == 8'd0);
  assign tmo_hit  = (tcnt == TW'(TIMEOUT - 1));
  assign clr_last = (ccnt == CW'(CLR_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    host.cmd_ready = 1'b0;
    host.rsp_valid = 1'b0;
    node_write_o   = 1'b0;
    node_read_o    = 1'b0;
    node_reset_o   = 1'b0;
    node_data_o    = 32'h0;
    case (state)
      IDLE: begin
        host.cmd_ready = 1'b1;
        accept         = host.cmd_valid;
        if (accept) begin
          case (host.cmd_op)
            OP_ENQ:  state_nxt = full  ? RESP : ISSUE;
            OP_DEQ:  state_nxt = empty ? RESP : ISSUE;
            OP_CLR:  state_nxt = CLEAR;
            default: state_nxt = RESP;
          endcase
        end
      end
      ISSUE: begin
        node_write_o = (op_q == OP_ENQ);
        node_read_o  = (op_q == OP_DEQ);
        node_data_o  = (op_q == OP_ENQ) ? data_q : 32'h0;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (node_done_i)  state_nxt = RESP;
        else if (tmo_hit) state_nxt = CLEAR;
      end
      CLEAR: begin
        node_reset_o = 1'b1;
        if (clr_last) state_nxt = RESP;
      end
      RESP: begin
        host.rsp_valid = 1'b1;
        if (host.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields are fixed at the transition into RESP and held there.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      op_q        <= OP_ENQ;
      data_q      <= 32'h0;
      tcnt        <= '0;
      ccnt        <= '0;
      rsp_data_q  <= 32'h0;
      rsp_empty_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q        <= host.cmd_op;
          data_q      <= host.cmd_data;
          ccnt        <= '0;
          rsp_data_q  <= 32'h0;
          rsp_empty_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          case (host.cmd_op)
            OP_ENQ:  if (full) rsp_err_q <= 1'b1;
            OP_DEQ:  if (empty) begin
                       rsp_empty_q <= 1'b1;
                       rsp_data_q  <= 32'hFFFF_FFFF;
                     end
            OP_CLR:  ;
            default: rsp_err_q <= 1'b1;
          endcase
        end
        ISSUE: tcnt <= '0;
        WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (node_done_i) begin
            if (op_q == OP_DEQ) begin
              rsp_data_q <= node_data_i;
              count_q    <= count_q - 8'd1;
            end else begin
              rsp_data_q <= data_q;
              count_q    <= count_q + 8'd1;
            end
          end else if (tmo_hit) begin
            // Abort: the chain state is unknown, so it gets reset via CLEAR.
            rsp_err_q  <= 1'b1;
            rsp_data_q <= 32'h0;
            ccnt       <= '0;
          end
        end
        CLEAR: begin
          count_q <= 8'd0;
          ccnt    <= ccnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_empty = rsp_empty_q;
  assign host.rsp_err   = rsp_err_q;
  assign count_o        = count_q;
endmodule

// File: tb/tb_qq_host_port.sv
// Directed bench for qq_host_port: a transaction table plus hand-built
// sequences for response back-pressure and reset during WAIT.
module tb_qq_host_port;
  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] node_data_o, node_data_i;
  logic        node_write_o, node_read_o, node_reset_o, node_done_i;
  logic [7:0]  count_o;

  qq_host_port_if h();

  qq_host_port #(.CAPACITY(2), .TIMEOUT(64), .CLR_CYCLES(4)) dut (
    .clk(clk), .reset_i(reset_i), .host(h),
    .node_data_o(node_data_o), .node_write_o(node_write_o),
    .node_read_o(node_read_o), .node_reset_o(node_reset_o),
    .node_data_i(node_data_i), .node_done_i(node_done_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          dly;      // strobe-to-done cycles, 0 = node never answers
    logic [31:0] nd;       // node_data_i presented at done
    int          exp_w, exp_r, exp_nrst, exp_lat;
    logic [31:0] exp_data;
    logic        exp_empty, exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[10];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One command through to response acceptance; hold = RESP cycles with rsp_ready low.
  task automatic run_txn(string tag, vec_t v, int hold);
    int cyc = 0, lat = -1, scyc = -1, nw = 0, nr = 0, nrst = 0, both = 0;
    logic [31:0] wdata = 32'h0;
    @(negedge clk);
    h.cmd_valid = 1'b1; h.cmd_op = v.op; h.cmd_data = v.data;
    node_data_i = v.nd; node_done_i = 1'b0;
    @(posedge clk);
    #1 h.cmd_valid = 1'b0;
    while (lat < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      node_done_i = 1'b0;
      if (h.rsp_valid) lat = cyc;
      else begin
        if (node_write_o && node_read_o) both++;
        if (node_write_o) begin nw++; wdata = node_data_o; scyc = cyc; end
        if (node_read_o) begin nr++; scyc = cyc; end
        if (node_reset_o) nrst++;
        if (scyc > 0 && v.dly > 0 && cyc == scyc + v.dly) node_done_i = 1'b1;
      end
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " write strobes"}, nw, v.exp_w);
    chk({tag, " read strobes"}, nr, v.exp_r);
    chk({tag, " dual strobe"}, both, 0);
    chk({tag, " node_reset cycles"}, nrst, v.exp_nrst);
    if (v.exp_w > 0) chk({tag, " node_data_o"}, wdata, v.data);
    chk({tag, " rsp_data"}, h.rsp_data, v.exp_data);
    chk({tag, " rsp_empty"}, h.rsp_empty, v.exp_empty);
    chk({tag, " rsp_err"}, h.rsp_err, v.exp_err);
    chk({tag, " count"}, count_o, v.exp_cnt);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      node_done_i = (k == 4);
      chk({tag, " held rsp_valid"}, h.rsp_valid, 1'b1);
      chk({tag, " held rsp_data"}, h.rsp_data, v.exp_data);
      chk({tag, " held cmd_ready"}, h.cmd_ready, 1'b0);
    end
    if (hold > 0) begin
      @(negedge clk);
      node_done_i = 1'b0;
      chk({tag, " count after stray done"}, count_o, v.exp_cnt);
    end
    h.rsp_ready = 1'b1;
    @(posedge clk);
    #1 h.rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " back to idle"}, {h.cmd_ready, h.rsp_valid}, 2'b10);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " cmd_ready"}, h.cmd_ready, 1'b1);
    chk({tag, " rsp flags/valid"}, {h.rsp_valid, h.rsp_empty, h.rsp_err}, 3'b000);
    chk({tag, " rsp_data"}, h.rsp_data, 32'h0);
    chk({tag, " strobes"}, {node_write_o, node_read_o, node_reset_o}, 3'b000);
    chk({tag, " node_data_o"}, node_data_o, 32'h0);
    chk({tag, " count"}, count_o, 8'd0);
  endtask

  initial begin
    vec_t v;
    //          op     data          dly nd           w r rst lat data          em er cnt
    tbl[0] = '{2'b00, 32'h10,        3, 32'h0,       1,0,0,  5, 32'h10,        0, 0, 8'd1};
    tbl[1] = '{2'b00, 32'h20,        1, 32'h0,       1,0,0,  3, 32'h20,        0, 0, 8'd2};
    tbl[2] = '{2'b00, 32'h30,        1, 32'h0,       0,0,0,  1, 32'h0,         0, 1, 8'd2};
    tbl[3] = '{2'b01, 32'h0,         2, 32'h5,       0,1,0,  4, 32'h5,         0, 0, 8'd1};
    tbl[4] = '{2'b01, 32'h0,         1, 32'hAB,      0,1,0,  3, 32'hAB,        0, 0, 8'd0};
    tbl[5] = '{2'b01, 32'h0,         1, 32'h1234,    0,0,0,  1, 32'hFFFF_FFFF, 1, 0, 8'd0};
    tbl[6] = '{2'b11, 32'h77,        1, 32'h0,       0,0,0,  1, 32'h0,         0, 1, 8'd0};
    tbl[7] = '{2'b00, 32'hDEADBEEF,  2, 32'h0,       1,0,0,  4, 32'hDEADBEEF,  0, 0, 8'd1};
    tbl[8] = '{2'b10, 32'h0,         1, 32'h0,       0,0,4,  5, 32'h0,         0, 0, 8'd0};
    tbl[9] = '{2'b00, 32'h99,        0, 32'h0,       1,0,4, 70, 32'h0,         0, 1, 8'd0};

    reset_i = 1'b1; h.cmd_valid = 1'b0; h.cmd_op = 2'b00; h.cmd_data = 32'h0;
    h.rsp_ready = 1'b0; node_data_i = 32'h0; node_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), tbl[i], 0);

    // Response back-pressure with a stray done inside RESP.
    v = '{2'b00, 32'h42, 2, 32'hBAD0, 1,0,0, 4, 32'h42, 0, 0, 8'd1};
    run_txn("hold", v, 10);

    // Reset while the node is stalled in WAIT.
    @(negedge clk);
    h.cmd_valid = 1'b1; h.cmd_op = 2'b00; h.cmd_data = 32'h55; node_done_i = 1'b0;
    @(posedge clk);
    #1 h.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("wait pre-reset count", count_o, 8'd1);
    chk("wait pre-reset cmd_ready", h.cmd_ready, 1'b0);
    reset_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset in wait");
    reset_i = 1'b0;

    v = '{2'b00, 32'h7, 1, 32'h0, 1,0,0, 3, 32'h7, 0, 0, 8'd1};
    run_txn("recover", v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qq_host_port.md
# qq_host_port

Host-side front end for the QuickQueue node chain. It accepts enqueue, dequeue and clear commands from a valid/ready command interface and drives the left-hand port of the first queue node: data, write strobe, read strobe and reset. It waits for that node's done, then returns the dequeued value or a status on a valid/ready response interface. It tracks occupancy, so full and empty are resolved locally without touching the chain.

## Interface
- CAPACITY, 255: number of entries the node chain holds; occupancy saturates here.
- TIMEOUT, 64: maximum number of cycles in WAIT before the operation is aborted.
- CLR_CYCLES, 4: number of cycles node_reset_o is held high for a clear.
- clk  in  1  clock; all logic is on the rising edge.
- reset_i  in  1  reset, synchronous and active-high.
- cmd_valid_i  in  1  command present.
- cmd_op_i  in  2  00 enqueue, 01 dequeue, 10 clear, 11 reserved (treated as an error).
- cmd_data_i  in  32  enqueue value.
- cmd_ready_o  out  1  high only in IDLE.
- rsp_valid_o  out  1  response present.
- rsp_data_o  out  32  dequeued value or status fill.
- rsp_empty_o  out  1  dequeue was attempted on an empty queue.
- rsp_err_o  out  1  enqueue when full, timeout, or reserved op.
- rsp_ready_i  in  1  host accepts the response.
- node_data_o  out  32  goes to the first node's data_lt_i.
- node_write_o  out  1  one-cycle enqueue strobe.
- node_read_o  out  1  one-cycle dequeue strobe.
- node_reset_o  out  1  chain reset.
- node_data_i  in  32  from the first node's data_lt_o.
- node_done_i  in  1  the node has completed the current operation.
- count_o  out  8  current occupancy.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT, RESP and CLEAR.
- IDLE: cmd_ready_o=1. A command is accepted when cmd_valid_i and cmd_ready_o are both high, and op and data are latched.
  - Enqueue with count_o==CAPACITY: go to RESP with rsp_err_o=1 and rsp_data_o=32'h0. The node is not strobed.
  - Dequeue with count_o==0: go to RESP with rsp_empty_o=1 and rsp_data_o=32'hFFFFFFFF.
  - Clear: go to CLEAR.
  - Reserved op: go to RESP with rsp_err_o=1 and rsp_data_o=32'h0.
  - Any other command: go to ISSUE.
- ISSUE: lasts exactly one cycle.
  - node_write_o=1 for an enqueue, node_read_o=1 for a dequeue.
  - node_data_o equals the latched data for an enqueue and 32'h0 for a dequeue.
  - Next state is WAIT, and the timeout counter loads 0.
- WAIT: the timeout counter increments every cycle.
  - On node_done_i=1: a dequeue captures node_data_i into rsp_data_o and decrements count_o. An enqueue sets rsp_data_o to the enqueued value and increments count_o. Next state is RESP.
  - If the counter reaches TIMEOUT-1 without done: rsp_err_o=1, rsp_data_o=32'h0, count_o unchanged, and node_reset_o pulses for CLR_CYCLES via CLEAR. The response is issued after CLEAR completes, and count_o is then 0.
- CLEAR: node_reset_o=1 for CLR_CYCLES cycles. count_o is cleared to 0. Next state is RESP with rsp_data_o=32'h0 and no flags set (unless the clear was entered from a timeout).
- RESP: rsp_valid_o=1, and rsp_data_o and the flags are held stable. Go to IDLE on rsp_ready_i=1.
- node_done_i is ignored outside WAIT.
- count_o arithmetic is unsigned 8-bit. It never wraps, because the full and empty guards prevent overflow and underflow.

## Timing
- Reset values:
  - State IDLE; cmd_ready_o=1.
  - rsp_valid_o, rsp_empty_o, rsp_err_o = 0; rsp_data_o = 32'h0.
  - node_write_o, node_read_o, node_reset_o = 0; node_data_o = 32'h0; count_o = 0.
- reset_i asserted in any state returns to IDLE on the next edge and drops any in-flight strobe or response. node_reset_o is not asserted by reset_i.
- Normal enqueue or dequeue latency, from the accept edge to rsp_valid_o: 2 + D cycles, where D is the number of cycles from the strobe to node_done_i (D≥1).
- Full/empty rejects and reserved ops: rsp_valid_o rises 1 cycle after accept.
- Clear: rsp_valid_o rises CLR_CYCLES+1 cycles after accept.
- A response accepted with rsp_ready_i=1 in its first RESP cycle allows the next command to be accepted 1 cycle later, giving one command per 4+D cycles at best.
- The strobes are never asserted together, and are never asserted in IDLE, WAIT, RESP or CLEAR.

## Test plan
- After reset: enqueue 32'h10, node asserts done 3 cycles after the strobe -> node_write_o for 1 cycle with node_data_o=32'h10; rsp_valid_o 5 cycles after accept; count_o=1; no flags.
- Dequeue on an empty queue -> no node strobe; rsp_data_o=32'hFFFFFFFF, rsp_empty_o=1, count_o=0.
- With CAPACITY=2, three enqueues -> the third gives rsp_err_o=1 with no strobe; count_o stays 2. A following dequeue with node_data_i=32'h5 at done gives rsp_data_o=32'h5 and count_o=1.
- Node never asserts done (TIMEOUT=64) -> node_reset_o high for 4 cycles after 64 WAIT cycles; rsp_err_o=1; count_o=0.
- Hold rsp_ready_i low for 10 cycles -> rsp_valid_o and the data stay stable and cmd_ready_o stays 0; a stray node_done_i during RESP has no effect.
- reset_i asserted during WAIT -> IDLE on the next edge; count_o=0 and all outputs at their reset values.
